// File: rtl/vrf_pkg.sv
// Vector register file shared definitions: default geometry and the vector type.
package vrf_pkg;

    localparam int VRF_BITS  = 8;
    localparam int VRF_N     = 64;
    localparam int VRF_NREGS = 16;

    typedef logic [VRF_BITS-1:0] vec_t [VRF_N];

endpackage

// File: rtl/vrf_read_port.sv
// One read port of the vector register file: stall decision, optional
// write-to-read forwarding, and the registered result.
// Optional feature macro: VRF_BYPASS_EN (same-cycle write forwarding).
module vrf_read_port #(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rd_en,
    input  logic            i_pending,
    input  logic [BITS-1:0] i_reg_data [N],
    input  logic [BITS-1:0] i_reg_len,
    input  logic            i_wr_hit,
    input  logic [BITS-1:0] i_wr_data [N],
    input  logic [BITS-1:0] i_wr_len,
    output logic            o_stall,
    output logic            o_vld,
    output logic [BITS-1:0] o_data [N],
    output logic [BITS-1:0] o_len
);

`ifdef VRF_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic            w_hit;
    logic            w_accept;
    logic            r_vld;
    logic [BITS-1:0] r_data [N];
    logic [BITS-1:0] r_len;

    // A same-cycle write to the selected register only matters when forwarding is built in.
    assign w_hit    = BYPASS & i_wr_hit;
    assign o_stall  = i_rd_en & i_pending & ~w_hit;
    assign w_accept = i_rd_en & ~o_stall;

    // Capture the selected register (or the forwarded write) on an accepted request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_len  <= '0;
            r_data <= '{default: '0};
        end else begin
            r_vld <= w_accept;
            if (w_accept) begin
                if (w_hit) begin
                    r_data <= i_wr_data;
                    r_len  <= i_wr_len;
                end else begin
                    r_data <= i_reg_data;
                    r_len  <= i_reg_len;
                end
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_len  = r_len;

endmodule

// File: rtl/vec_reg_file.sv
// Vector register file: NREGS registers of N elements with per-register
// length, reservation (pending) flags and two independent read ports.
// Optional feature macro: VRF_BYPASS_EN (handled inside vrf_read_port).
module vec_reg_file
    import vrf_pkg::*;
#(
    parameter  int BITS  = VRF_BITS,
    parameter  int N     = VRF_N,
    parameter  int NREGS = VRF_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_sel,
    input  logic [BITS-1:0]  wr_data [N],
    input  logic [BITS-1:0]  wr_len,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_sel,
    input  logic             rd_a_en,
    input  logic [AW-1:0]    rd_a_sel,
    output logic             rd_a_stall,
    output logic             rd_a_vld,
    output logic [BITS-1:0]  rd_a_data [N],
    output logic [BITS-1:0]  rd_a_len,
    input  logic             rd_b_en,
    input  logic [AW-1:0]    rd_b_sel,
    output logic             rd_b_stall,
    output logic             rd_b_vld,
    output logic [BITS-1:0]  rd_b_data [N],
    output logic [BITS-1:0]  rd_b_len,
    output logic [NREGS-1:0] pending
);

    logic [BITS-1:0]  r_mem [NREGS][N];
    logic [BITS-1:0]  r_len [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [BITS-1:0]  w_len_w;
    logic [BITS-1:0]  w_wr_vec [N];

    // Lengths beyond the register size are clamped; elements past the length read as zero.
    assign w_len_w = (wr_len > BITS'(N)) ? BITS'(N) : wr_len;

    for (genvar g = 0; g < N; g++) begin : g_tail
        assign w_wr_vec[g] = (BITS'(g) < w_len_w) ? wr_data[g] : '0;
    end

    // Register storage and lengths; writes are never refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '{default: '0}};
            r_len <= '{default: '0};
        end else if (wr_en) begin
            r_mem[wr_sel] <= w_wr_vec;
            r_len[wr_sel] <= w_len_w;
        end
    end

    // Pending flags: a reservation wins over a same-cycle write to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (wr_en)  r_pending[wr_sel]  <= 1'b0;
            if (rsv_en) r_pending[rsv_sel] <= 1'b1;
        end
    end

    assign pending = r_pending;

    vrf_read_port #(.BITS(BITS), .N(N)) u_port_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_en    (rd_a_en),
        .i_pending  (r_pending[rd_a_sel]),
        .i_reg_data (r_mem[rd_a_sel]),
        .i_reg_len  (r_len[rd_a_sel]),
        .i_wr_hit   (wr_en && (wr_sel == rd_a_sel)),
        .i_wr_data  (w_wr_vec),
        .i_wr_len   (w_len_w),
        .o_stall    (rd_a_stall),
        .o_vld      (rd_a_vld),
        .o_data     (rd_a_data),
        .o_len      (rd_a_len)
    );

    vrf_read_port #(.BITS(BITS), .N(N)) u_port_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_en    (rd_b_en),
        .i_pending  (r_pending[rd_b_sel]),
        .i_reg_data (r_mem[rd_b_sel]),
        .i_reg_len  (r_len[rd_b_sel]),
        .i_wr_hit   (wr_en && (wr_sel == rd_b_sel)),
        .i_wr_data  (w_wr_vec),
        .i_wr_len   (w_len_w),
        .o_stall    (rd_b_stall),
        .o_vld      (rd_b_vld),
        .o_data     (rd_b_data),
        .o_len      (rd_b_len)
    );

endmodule

// File: tb/tb_vec_reg_file.sv
// Bench for vec_reg_file: directed vectors checked every cycle against a
// behavioural model of the register file, plus literal spot checks.
module tb_vec_reg_file;
    import vrf_pkg::*;

    localparam int BITS  = VRF_BITS;
    localparam int N     = VRF_N;
    localparam int NREGS = VRF_NREGS;
    localparam int AW    = $clog2(NREGS);
`ifdef VRF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, wr_en, rsv_en;
    logic [AW-1:0]    wr_sel, rsv_sel;
    vec_t             wr_data;
    logic [BITS-1:0]  wr_len;
    logic             rd_en  [2];
    logic [AW-1:0]    rd_sel [2];
    logic             a_stall, b_stall, a_vld, b_vld;
    vec_t             a_data, b_data;
    logic [BITS-1:0]  a_len, b_len;
    logic [NREGS-1:0] pending;

    vec_reg_file dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_len(wr_len),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .rd_a_en(rd_en[0]), .rd_a_sel(rd_sel[0]), .rd_a_stall(a_stall), .rd_a_vld(a_vld),
        .rd_a_data(a_data), .rd_a_len(a_len),
        .rd_b_en(rd_en[1]), .rd_b_sel(rd_sel[1]), .rd_b_stall(b_stall), .rd_b_vld(b_vld),
        .rd_b_data(b_data), .rd_b_len(b_len),
        .pending(pending)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model
    vec_t m_mem  [NREGS];
    int   m_len  [NREGS];
    bit   m_pend [NREGS];
    bit   e_vld  [2];
    vec_t e_data [2];
    int   e_len  [2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        int bad;
        bad = -1;
        n_chk++;
        for (int i = N - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s element %0d actual=%0d required=%0d", name, bad, act[bad], exp[bad]);
        end
    endtask

    task automatic check_outputs();
        int pm;
        pm = 0;
        for (int r = 0; r < NREGS; r++) if (m_pend[r]) pm |= (1 << r);
        chk("vld_a", int'(a_vld), int'(e_vld[0]));
        chk("vld_b", int'(b_vld), int'(e_vld[1]));
        chk("len_a", int'(a_len), e_len[0]);
        chk("len_b", int'(b_len), e_len[1]);
        chk_vec("data_a", a_data, e_data[0]);
        chk_vec("data_b", b_data, e_data[1]);
        chk("pending", int'(pending), pm);
    endtask

    // One clock cycle: check stalls, advance the model across the edge, check outputs.
    task automatic step();
        int   lw;
        bit   hit [2];
        bit   st  [2];
        vec_t wv;
        #1;
        lw = (int'(wr_len) > N) ? N : int'(wr_len);
        for (int i = 0; i < N; i++) wv[i] = (i < lw) ? wr_data[i] : 8'h00;
        for (int p = 0; p < 2; p++) begin
            hit[p] = wr_en && (wr_sel == rd_sel[p]);
            st[p]  = rd_en[p] && m_pend[rd_sel[p]] && !(BYPASS && hit[p]);
        end
        chk("stall_a", int'(a_stall), int'(st[0]));
        chk("stall_b", int'(b_stall), int'(st[1]));
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_len[r] = 0; m_pend[r] = 0;
                for (int i = 0; i < N; i++) m_mem[r][i] = 8'h00;
            end
            for (int p = 0; p < 2; p++) begin
                e_vld[p] = 0; e_len[p] = 0;
                for (int i = 0; i < N; i++) e_data[p][i] = 8'h00;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                e_vld[p] = rd_en[p] && !st[p];
                if (e_vld[p]) begin
                    if (BYPASS && hit[p]) begin
                        e_data[p] = wv; e_len[p] = lw;
                    end else begin
                        e_data[p] = m_mem[rd_sel[p]]; e_len[p] = m_len[rd_sel[p]];
                    end
                end
            end
            if (wr_en) begin
                m_mem[wr_sel]  = wv;
                m_len[wr_sel]  = lw;
                m_pend[wr_sel] = 0;
            end
            if (rsv_en) m_pend[rsv_sel] = 1;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; rsv_en = 0; rd_en[0] = 0; rd_en[1] = 0;
    endtask

    task automatic set_wr(input int sel, input int len, input int base, input int mul);
        wr_en = 1; wr_sel = AW'(sel); wr_len = BITS'(len);
        for (int i = 0; i < N; i++) wr_data[i] = 8'(base + mul * i);
    endtask

    task automatic set_rd(input int p, input int sel);
        rd_en[p] = 1; rd_sel[p] = AW'(sel);
    endtask

    initial begin
        idle();
        rst = 1; wr_sel = '0; rsv_sel = '0; wr_len = '0; rd_sel[0] = '0; rd_sel[1] = '0;
        for (int i = 0; i < N; i++) wr_data[i] = 8'h00;
        step(); step();
        chk("lit_reset_pending", int'(pending), 0);

        // tail zeroing, short length
        idle(); set_wr(3, 5, 1, 1); step();
        idle(); set_rd(0, 3); step();
        chk("lit_len5", int'(a_len), 5);
        chk("lit_d0", int'(a_data[0]), 1);
        chk("lit_d4", int'(a_data[4]), 5);
        chk("lit_d5_zero", int'(a_data[5]), 0);

        // length clamp
        idle(); set_wr(7, 200, 7, 3); step();
        idle(); set_rd(1, 7); step();
        chk("lit_len_clamp", int'(b_len), 64);
        chk("lit_d63", int'(b_data[63]), 196);

        // reservation stalls until written
        idle(); rsv_en = 1; rsv_sel = 2; step();
        chk("lit_pend2_set", int'(pending[2]), 1);
        idle(); set_rd(1, 2); #1;
        chk("lit_stall_b", int'(b_stall), 1);
        step();
        chk("lit_vld_b_stalled", int'(b_vld), 0);
        idle(); set_wr(2, 64, 8'h11, 0); step();
        chk("lit_pend2_clr", int'(pending[2]), 0);
        idle(); set_rd(1, 2); step();
        chk("lit_new_data", int'(b_data[0]), 8'h11);

        // reserve and write same register in one cycle
        idle(); set_wr(5, 10, 2, 1); rsv_en = 1; rsv_sel = 5; step();
        chk("lit_pend5_wins", int'(pending[5]), 1);

        // same register on both ports
        idle(); set_rd(0, 3); set_rd(1, 3); step();

        // read during write of the same register
        idle(); set_wr(4, 64, 8'hAA, 0); step();
        idle(); set_wr(4, 64, 8'h55, 0); set_rd(0, 4); step();
        chk("lit_rw_same", int'(a_data[0]), BYPASS ? 8'h55 : 8'hAA);

        // pending register read with a same-cycle write to it
        idle(); rsv_en = 1; rsv_sel = 6; step();
        idle(); set_wr(6, 3, 9, 2); set_rd(0, 6); set_rd(1, 5); step();
        idle(); set_rd(0, 6); step();

        // reset mid-sequence of reads on both ports
        idle(); set_wr(9, 40, 100, 1); step();
        idle(); set_rd(0, 9); set_rd(1, 9); rsv_en = 1; rsv_sel = 1; step();
        chk("lit_vld_before_rst", int'(a_vld), 1);
        set_rd(0, 9); set_rd(1, 9); rst = 1; set_wr(9, 5, 1, 1); rsv_en = 1; rsv_sel = 9; step();
        chk("lit_rst_vld_a", int'(a_vld), 0);
        chk("lit_rst_vld_b", int'(b_vld), 0);
        chk("lit_rst_data_b", int'(b_data[10]), 0);
        chk("lit_rst_pending", int'(pending), 0);
        idle(); set_rd(0, 9); set_rd(1, 7); step();
        chk("lit_rst_len9", int'(a_len), 0);
        chk("lit_rst_len7", int'(b_len), 0);
        idle(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
